turfbus_bridge: RTL

TURFBUS_BRIDGE -- requirements
Module: turfbus_bridge

---
 rtl/turfbus_bridge.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/turfbus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : turfbus_bridge
// Description : Bit-serial TURFbus command/response link to a Wishbone
//               classic master. A command frame (start bit, header, optional
//               write data) is shifted in on TREQ, executed as a single
//               Wishbone cycle with timeout, and answered on SREQ with a
//               start bit, a status bit and, for successful reads, the data.
//               Optional feature macro: TURFBUS_PARITY_EN (adds a trailing
//               even-parity bit checked before the bus cycle is issued).
// Revision    : 1.0 - initial release
// ============================================================================
module turfbus_bridge #(
    parameter int LANES      = 1,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    wbm_clk_i,
    input  logic                    wbm_rst_n_i,
    input  logic [LANES-1:0]        TREQ_neg,
    output logic [LANES-1:0]        SREQ_neg,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    output logic                    busy_o,
    output logic [7:0]              err_count_o
);

    // Header register keeps only WE + address; leading pad bits fall off the top.
    localparam int          HW        = ADDR_WIDTH + 1;
    localparam int          HDR_BITS  = ((ADDR_WIDTH + 1 + LANES - 1) / LANES) * LANES;
    localparam logic [15:0] HDR_LAST  = 16'(HDR_BITS / LANES - 1);
    localparam logic [15:0] DATA_LAST = 16'(DATA_WIDTH / LANES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR       = 3'd1,
        DATA      = 3'd2,
        PAR       = 3'd3,
        WB        = 3'd4,
        RSP_START = 3'd5,
        RSP_STAT  = 3'd6,
        RSP_DATA  = 3'd7
    } state_t;

    state_t                  state;
    logic [15:0]             cnt;
    logic [15:0]             tmo;
    logic [HW-1:0]           hdr_sr;
    logic [DATA_WIDTH-1:0]   data_sr;
    logic [DATA_WIDTH-1:0]   rsp_sr;
    logic [LANES-1:0]        sreq;
    logic                    err_flag;
    logic [7:0]              err_cnt;
`ifdef TURFBUS_PARITY_EN
    logic                    parity_acc;
`endif

    logic [LANES-1:0]        treq;
    logic [HW-1:0]           hdr_next;
    logic [DATA_WIDTH-1:0]   data_next;
    logic [LANES-1:0]        rsp_chunk;
    logic [DATA_WIDTH-1:0]   rsp_shift;
    logic                    wb_done;
    logic                    wb_error;

    assign treq        = ~TREQ_neg;
    assign SREQ_neg    = ~sreq;
    assign busy_o      = (state != IDLE);
    assign err_count_o = err_cnt;

    // Incoming chunks enter at the bottom, highest lane most significant.
    assign hdr_next  = (hdr_sr << LANES) | HW'(treq);
    assign data_next = (data_sr << LANES) | DATA_WIDTH'(treq);

    // Outgoing read data leaves from the top, MSB first.
    assign rsp_chunk = rsp_sr[DATA_WIDTH-1 -: LANES];
    assign rsp_shift = rsp_sr << LANES;

    // A bus cycle ends on ack, err, or the last cycle of the timeout window.
    assign wb_done  = wbm_ack_i | wbm_err_i | (tmo == TMO_LAST);
    assign wb_error = wbm_err_i | ~wbm_ack_i;

    // Frame sequencer: deserialise command, run bus cycle, serialise response.
    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n_i) begin
        if (!wbm_rst_n_i) begin
            state      <= IDLE;
            cnt        <= '0;
            tmo        <= '0;
            hdr_sr     <= '0;
            data_sr    <= '0;
            rsp_sr     <= '0;
            sreq       <= '0;
            err_flag   <= 1'b0;
            err_cnt    <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            wbm_sel_o  <= '0;
`ifdef TURFBUS_PARITY_EN
            parity_acc <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    sreq <= '0;
                    if (treq[0]) begin
                        state    <= HDR;
                        cnt      <= '0;
                        hdr_sr   <= '0;
                        data_sr  <= '0;
                        err_flag <= 1'b0;
`ifdef TURFBUS_PARITY_EN
                        parity_acc <= 1'b0;
`endif
                    end
                end

                HDR: begin
                    hdr_sr <= hdr_next;
`ifdef TURFBUS_PARITY_EN
                    parity_acc <= parity_acc ^ (^treq);
`endif
                    if (cnt == HDR_LAST) begin
                        cnt <= '0;
                        if (hdr_next[ADDR_WIDTH]) begin
                            state <= DATA;
                        end else begin
`ifdef TURFBUS_PARITY_EN
                            state <= PAR;
`else
                            state     <= WB;
                            tmo       <= '0;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b0;
                            wbm_adr_o <= hdr_next[ADDR_WIDTH-1:0];
                            wbm_dat_o <= '0;
                            wbm_sel_o <= '1;
`endif
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DATA: begin
                    data_sr <= data_next;
`ifdef TURFBUS_PARITY_EN
                    parity_acc <= parity_acc ^ (^treq);
`endif
                    if (cnt == DATA_LAST) begin
                        cnt <= '0;
`ifdef TURFBUS_PARITY_EN
                        state <= PAR;
`else
                        state     <= WB;
                        tmo       <= '0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_adr_o <= hdr_sr[ADDR_WIDTH-1:0];
                        wbm_dat_o <= data_next;
                        wbm_sel_o <= '1;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

`ifdef TURFBUS_PARITY_EN
                PAR: begin
                    if (treq[0] == parity_acc) begin
                        state     <= WB;
                        tmo       <= '0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= hdr_sr[ADDR_WIDTH];
                        wbm_adr_o <= hdr_sr[ADDR_WIDTH-1:0];
                        wbm_dat_o <= hdr_sr[ADDR_WIDTH] ? data_sr : '0;
                        wbm_sel_o <= '1;
                    end else begin
                        // Corrupted command: never touch the bus, report error.
                        state    <= RSP_START;
                        sreq     <= LANES'(1);
                        err_flag <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
`endif

                WB: begin
                    if (wb_done) begin
                        state     <= RSP_START;
                        sreq      <= LANES'(1);
                        tmo       <= '0;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_adr_o <= '0;
                        wbm_dat_o <= '0;
                        wbm_sel_o <= '0;
                        if (wb_error) begin
                            err_flag <= 1'b1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                        end else begin
                            rsp_sr <= wbm_dat_i;
                        end
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end

                RSP_START: begin
                    state <= RSP_STAT;
                    sreq  <= LANES'(err_flag);
                end

                RSP_STAT: begin
                    // Writes and failed cycles carry no data phase.
                    if (err_flag || hdr_sr[ADDR_WIDTH]) begin
                        state <= IDLE;
                        sreq  <= '0;
                    end else begin
                        state  <= RSP_DATA;
                        cnt    <= '0;
                        sreq   <= rsp_chunk;
                        rsp_sr <= rsp_shift;
                    end
                end

                RSP_DATA: begin
                    if (cnt == DATA_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        sreq  <= '0;
                    end else begin
                        cnt    <= cnt + 16'd1;
                        sreq   <= rsp_chunk;
                        rsp_sr <= rsp_shift;
                    end
                end

                default: begin
                    state <= IDLE;
                    sreq  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
